// File: rtl/cache_miss_controller.sv
// Miss/store controller for a direct-mapped cache: load hits respond in the request cycle,
// misses and write-through stores stall the pipeline until memory acks or the timeout expires.
module cache_miss_controller #(
  parameter int INPUT_WIDTH    = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [INPUT_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   stall,
  output logic                   resp_valid,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   resp_error,
  output logic [INPUT_WIDTH-1:0] cache_addr,
  output logic                   cache_read_write,
  output logic [DATA_WIDTH-1:0]  cache_data_in,
  output logic                   cache_valid_in,
  input  logic                   cache_hit,
  input  logic [DATA_WIDTH-1:0]  cache_data_out,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic [INPUT_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, MEM_WAIT, FILL, RESPOND, ERROR} state_t;

  state_t                 state;
  logic [INPUT_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [DATA_WIDTH-1:0]  cap_data;
  logic [DATA_WIDTH-1:0]  resp_data_r;
  logic                   lat_write;
  logic                   mem_req_r;
  logic                   fill_r;
  logic                   resp_valid_r;
  logic                   resp_error_r;
  logic [CW-1:0]          tcnt;

  logic idle_act;
  logic load_hit;
  logic store_hit;
  logic accept;

  // IDLE decisions are combinational so hits cost no cycle; reset masks them.
  always_comb begin
    idle_act  = (state == IDLE) && !reset;
    load_hit  = idle_act && req_valid && !req_write && cache_hit;
    store_hit = idle_act && req_valid && req_write && cache_hit;
    accept    = idle_act && req_valid && !load_hit;
  end

  assign stall            = accept || (state == MEM_WAIT) || (state == FILL);
  assign resp_valid       = load_hit || resp_valid_r;
  assign resp_data        = load_hit ? cache_data_out : resp_data_r;
  assign resp_error       = resp_error_r;
  assign cache_addr       = (state == IDLE) ? req_addr : lat_addr;
  assign cache_read_write = store_hit || fill_r;
  assign cache_valid_in   = store_hit || fill_r;
  assign cache_data_in    = fill_r ? cap_data : (store_hit ? req_wdata : '0);
  assign mem_req          = mem_req_r;
  assign mem_write        = mem_req_r && lat_write;
  assign mem_addr         = lat_addr;
  assign mem_wdata        = lat_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_write    <= 1'b0;
      cap_data     <= '0;
      resp_data_r  <= '0;
      mem_req_r    <= 1'b0;
      fill_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      tcnt         <= '0;
    end else begin
      fill_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_data_r  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_wdata <= req_write ? req_wdata : '0;
            mem_req_r <= 1'b1;
            tcnt      <= '0;
            state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // An ack on the terminal-count cycle still completes normally.
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            tcnt      <= '0;
            if (lat_write) begin
              resp_valid_r <= 1'b1;
              state        <= RESPOND;
            end else begin
              cap_data <= mem_rdata;
              fill_r   <= 1'b1;
              state    <= FILL;
            end
          end else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_r    <= 1'b0;
            tcnt         <= '0;
            resp_valid_r <= 1'b1;
            resp_error_r <= 1'b1;
            state        <= ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FILL: begin
          resp_valid_r <= 1'b1;
          resp_data_r  <= cap_data;
          state        <= RESPOND;
        end
        RESPOND: state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_controller.sv
module tb_cache_miss_controller;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, resp_error;
  logic [31:0] resp_data, cache_addr, cache_data_in, cache_data_out;
  logic        cache_read_write, cache_valid_in, cache_hit;
  logic        mem_req, mem_write, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_miss_controller #(.INPUT_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .cache_addr(cache_addr), .cache_read_write(cache_read_write), .cache_data_in(cache_data_in),
    .cache_valid_in(cache_valid_in), .cache_hit(cache_hit), .cache_data_out(cache_data_out),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Environment: 4-line direct-mapped cache array (index addr[3:2], tag addr[31:4]).
  bit          cache_clr = 1'b1;
  logic        c_v   [4];
  logic [27:0] c_tag [4];
  logic [31:0] c_dat [4];
  assign cache_hit      = c_v[cache_addr[3:2]] && (c_tag[cache_addr[3:2]] == cache_addr[31:4]);
  assign cache_data_out = c_dat[cache_addr[3:2]];
  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 4; i++) c_v[i] <= 1'b0;
    end else if (cache_read_write) begin
      c_v[cache_addr[3:2]]   <= cache_valid_in;
      c_tag[cache_addr[3:2]] <= cache_addr[31:4];
      c_dat[cache_addr[3:2]] <= cache_data_in;
    end
  end

  // Environment memory and the independent reference model.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_v   [4];
  logic [27:0] ref_tag [4];
  logic [31:0] ref_dat [4];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline request; lat = cycle of mem_req on which memory acks, 0 = never.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int          idx;
    bit          hit;
    bit          tmo;
    int          nreq;
    logic [31:0] exp_d;
    idx  = int'(addr[3:2]);
    hit  = ref_v[idx] && (ref_tag[idx] == addr[31:4]);
    tmo  = !(lat >= 1 && lat <= T);
    nreq = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("idle_cache_addr", 64'(cache_addr), 64'(addr));
    if (!wr && hit) begin
      chk("hit_resp_valid", 64'(resp_valid), 64'(1));
      chk("hit_resp_data", 64'(resp_data), 64'(ref_dat[idx]));
      chk("hit_stall", 64'(stall), 64'(0));
      chk("hit_mem_req", 64'(mem_req), 64'(0));
      @(posedge clk); #1;
      req_valid = 1'b0;
      return;
    end
    chk("acc_stall", 64'(stall), 64'(1));
    chk("acc_resp_valid", 64'(resp_valid), 64'(0));
    chk("acc_cache_we", 64'(cache_read_write), 64'(wr && hit));
    if (wr && hit) begin
      chk("acc_cache_din", 64'(cache_data_in), 64'(wd));
      ref_dat[idx] = wd;
    end
    @(posedge clk); #1;
    for (int c = 0; c < 3 * T; c++) begin
      @(negedge clk);
      if (!mem_req) break;
      nreq++;
      chk("wait_mem_addr", 64'(mem_addr), 64'(addr));
      chk("wait_mem_write", 64'(mem_write), 64'(wr));
      if (wr) chk("wait_mem_wdata", 64'(mem_wdata), 64'(wd));
      chk("wait_stall", 64'(stall), 64'(1));
      if (nreq == lat) begin
        mem_ack = 1'b1;
        if (mem_write) env_mem[mem_addr] = mem_wdata;
        else mem_rdata = env_rd(mem_addr);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = '0;
    end
    chk("mem_req_cycles", 64'(nreq), 64'(tmo ? T : lat));
    if (tmo) begin
      chk("err_resp_valid", 64'(resp_valid), 64'(1));
      chk("err_resp_error", 64'(resp_error), 64'(1));
      chk("err_resp_data", 64'(resp_data), 64'(0));
      chk("err_cache_we", 64'(cache_read_write), 64'(0));
      chk("err_stall", 64'(stall), 64'(0));
    end else if (!wr) begin
      exp_d = ref_rd(addr);
      chk("fill_we", 64'(cache_read_write), 64'(1));
      chk("fill_valid", 64'(cache_valid_in), 64'(1));
      chk("fill_din", 64'(cache_data_in), 64'(exp_d));
      chk("fill_addr", 64'(cache_addr), 64'(addr));
      chk("fill_stall", 64'(stall), 64'(1));
      chk("fill_resp_valid", 64'(resp_valid), 64'(0));
      ref_v[idx] = 1'b1; ref_tag[idx] = addr[31:4]; ref_dat[idx] = exp_d;
      @(posedge clk); #1;
      @(negedge clk);
      chk("resp_valid", 64'(resp_valid), 64'(1));
      chk("resp_data", 64'(resp_data), 64'(exp_d));
      chk("resp_error", 64'(resp_error), 64'(0));
      chk("resp_stall", 64'(stall), 64'(0));
    end else begin
      ref_mem[addr] = wd;
      chk("st_resp_valid", 64'(resp_valid), 64'(1));
      chk("st_resp_data", 64'(resp_data), 64'(0));
      chk("st_resp_error", 64'(resp_error), 64'(0));
      chk("st_cache_we", 64'(cache_read_write), 64'(0));
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    int n_resp;
    int n_we;
    logic [31:0] a;
    int r;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h1234; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin ref_v[i] = 1'b0; ref_tag[i] = '0; ref_dat[i] = '0; end
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_cache_we", 64'(cache_read_write), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_cache_addr", 64'(cache_addr), 64'(32'h1234));
    @(posedge clk); #1;
    reset = 1'b0; cache_clr = 1'b0;

    env_mem[32'h8]  = 32'hDEADBEEF; ref_mem[32'h8]  = 32'hDEADBEEF;
    env_mem[32'h14] = 32'h12345678; ref_mem[32'h14] = 32'h12345678;
    do_req(1'b0, 32'h8, '0, 2);
    do_req(1'b0, 32'h8, '0, 1);
    do_req(1'b0, 32'h8, '0, 1);
    do_req(1'b0, 32'h14, '0, 3);
    do_req(1'b0, 32'h14, '0, 1);
    do_req(1'b1, 32'h14, 32'hCAFEF00D, 2);
    do_req(1'b0, 32'h14, '0, 1);
    do_req(1'b1, 32'h30, 32'h0BADC0DE, 1);
    do_req(1'b0, 32'h30, '0, 1);
    do_req(1'b0, 32'h20, '0, 0);
    do_req(1'b0, 32'h20, '0, 2);
    do_req(1'b0, 32'h24, '0, T);

    // Reset while waiting on memory, then a late ack.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h38;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", 64'(mem_req), 64'(0));
    chk("abort_stall", 64'(stall), 64'(0));
    chk("abort_mem_addr", 64'(mem_addr), 64'(0));
    chk("abort_mem_write", 64'(mem_write), 64'(0));
    n_resp = 0; n_we = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      mem_ack = (c == 0); mem_rdata = (c == 0) ? 32'h77777777 : '0;
      @(negedge clk);
      n_resp += int'(resp_valid); n_we += int'(cache_read_write) + int'(mem_req);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("abort_no_resp", 64'(n_resp), 64'(0));
    chk("abort_no_write", 64'(n_we), 64'(0));
    do_req(1'b0, 32'h38, '0, 2);

    // Unsolicited ack in IDLE.
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("stale_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stale_mem_req", 64'(mem_req), 64'(0));
    chk("stale_resp_valid", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;

    // Tag conflict on index 1.
    do_req(1'b0, 32'h04, '0, 1);
    do_req(1'b0, 32'h14, '0, 2);
    do_req(1'b0, 32'h04, '0, 1);

    for (int k = 0; k < 60; k++) begin
      a = 32'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2));
      r = int'($urandom_range(0, 9));
      do_req(1'($urandom_range(0, 1)), a, $urandom,
             (r == 0) ? 0 : ((r == 1) ? T : int'($urandom_range(1, 4))));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Sequential controller between the pipeline's memory stage and main memory; owns the fill/update port of the direct-mapped cache array.
- Responds to pipeline load/store requests:
  - Load hits are served directly from the cache's combinational read.
  - Load misses fetch the word from memory, write it into the addressed cache line, then return the data.
  - Stores are write-through, no-allocate.
- Drives the cache's read_write, data_in, valid_in and address inputs, and consumes its hit and data_out outputs.

Parameters:
- INPUT_WIDTH, 32, address width; matches the cache address input.
- DATA_WIDTH, 32, data word width; matches the cache data path.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for a memory response before signalling an error; must be ≥2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present; held stable while stall=1
- req_write  in  1  1=store, 0=load
- req_addr  in  INPUT_WIDTH  request address
- req_wdata  in  DATA_WIDTH  store data
- stall  out  1  pipeline must hold its request
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_WIDTH  load result; valid when resp_valid=1 and the request was a load
- resp_error  out  1  qualifies resp_valid: memory timeout
- cache_addr  out  INPUT_WIDTH  address to the cache array
- cache_read_write  out  1  cache line write enable
- cache_data_in  out  DATA_WIDTH  line write data
- cache_valid_in  out  1  valid bit written with the line
- cache_hit  in  1  cache hit for cache_addr, combinational
- cache_data_out  in  DATA_WIDTH  cache line data for cache_addr
- mem_req  out  1  memory request, held until mem_ack
- mem_write  out  1  memory store
- mem_addr  out  INPUT_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory store data
- mem_ack  in  1  one-cycle response or acknowledge
- mem_rdata  in  DATA_WIDTH  load data; valid with mem_ack

Behaviour:
- **States:** IDLE, MEM_WAIT, FILL, RESPOND, ERROR.
- **Reset:**
  - State goes to IDLE.
  - All outputs are 0, except cache_addr, which follows req_addr combinationally.
  - The latched address, data, op and timeout counter clear to 0.
- **IDLE:**
  - cache_addr = req_addr (combinational).
  - Load hit (req_valid=1, req_write=0, cache_hit=1):
    - resp_valid=1 and resp_data=cache_data_out in the same cycle; stall=0.
    - Stay in IDLE. Zero-latency hits allow back-to-back hits, one per cycle.
  - Load miss:
    - stall=1 combinationally.
    - Latch addr and op.
    - Assert mem_req with mem_write=0 from the next cycle.
    - Go to MEM_WAIT.
  - Store:
    - stall=1.
    - If cache_hit=1 in this cycle, assert cache_read_write=1, cache_data_in=req_wdata, cache_valid_in=1 in this same cycle. This updates the line.
    - Latch addr, wdata and op.
    - Go to MEM_WAIT with mem_req=1, mem_write=1.
  - mem_ack while in IDLE (stale or unsolicited) is ignored.
- **MEM_WAIT:**
  - stall=1; mem_req, mem_addr, mem_write and mem_wdata come from registers and are held stable.
  - cache_addr = latched addr.
  - The timeout counter increments each cycle.
  - On mem_ack:
    - mem_req drops in the next cycle.
    - A load captures mem_rdata and goes to FILL.
    - A store goes to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES-1 without mem_ack: drop mem_req and go to ERROR.
  - A mem_ack in the same cycle as the terminal count wins: the normal path is taken.
- **FILL:**
  - One cycle: cache_read_write=1, cache_addr=latched addr, cache_data_in=captured data, cache_valid_in=1; stall=1.
  - Go to RESPOND.
- **RESPOND:**
  - One cycle: resp_valid=1; stall=0.
  - resp_data = captured data for loads, 0 for stores.
  - Go to IDLE. The pipeline advances on this cycle; the next request is sampled in IDLE the following cycle.
- **ERROR:**
  - One cycle: resp_valid=1, resp_error=1, resp_data=0, stall=0.
  - No cache write. Go to IDLE.
- **Total load-miss latency:** the accept cycle, N wait cycles until mem_ack, the FILL cycle, then RESPOND.
- **Reset mid-operation:** the state returns to IDLE next cycle and mem_req deasserts. No cache write or response is issued for the aborted request. A late mem_ack is ignored.
- **req_valid=0 in IDLE:** no action; stall=0, resp_valid=0.
- **Counter width:** $clog2(TIMEOUT_CYCLES)+1 bits. It clears on leaving MEM_WAIT.

Test Plan:
- **Load hit:** preload line 2 (addr 0x0000_0008) with 0xDEADBEEF via the miss path, then load 0x8 → resp_valid=1 with resp_data=0xDEADBEEF in the request cycle; mem_req stays 0.
- **Load miss:** load 0x0000_0014; memory acks after 3 cycles with 0x12345678 →
  - mem_req is high for 3 cycles with mem_addr=0x14;
  - a FILL cycle writes 0x12345678 with valid=1;
  - RESPOND returns 0x12345678;
  - a repeat load of 0x14 hits.
- **Store hit then store miss:**
  - Store 0xCAFEF00D to a cached address → a cache write in the accept cycle, mem_write=1, resp after ack, and a subsequent load hits with 0xCAFEF00D.
  - Store to an uncached address → no cache write; a subsequent load misses.
- **Timeout (TIMEOUT_CYCLES=8):** a load miss that is never acked → mem_req is high for 8 cycles, then ERROR: resp_valid=1, resp_error=1; no cache write; a later load of the same address still misses.
- **Reset mid-operation:** assert reset during MEM_WAIT, then pulse mem_ack 2 cycles later → IDLE, all outputs 0; no FILL and no resp_valid.
- **Tag conflict:** load 0x04, then load 0x14 (same set, different tag) → the second load misses and refills; reloading 0x04 then misses.
